// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text cursor controller.
//   state_t     : controller states (IDLE, CLEAR_ROW, CLEAR_ALL)
//   ASCII_*     : control codes recognised by the cursor logic
//   DEF_COLS/ROWS : default screen geometry
//   is_printable: 1 for codes 0x20..0x7E
package vga_text_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR_ROW = 2'd1,
      CLEAR_ALL = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_TAB   = 8'h09;
   localparam logic [7:0] ASCII_BLANK = 8'h20;

   localparam int unsigned DEF_COLS = 80;
   localparam int unsigned DEF_ROWS = 30;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Text cursor controller between the keyboard ASCII stream and the VGA
// character RAM. Handles printable writes, wrap, CR/LF, tab, backspace,
// row clearing on line advance and full-screen clearing.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   char_ready, char_data : one-cycle ASCII strobe from the keyboard
//   clear_screen          : one-cycle request to blank the screen and home
//   vga_char_wr/in/x/y    : character RAM write strobe, data and cell address
//   cursor_x, cursor_y    : current cursor position
//   busy                  : not IDLE, or a character is waiting in the hold reg
//   overflow              : sticky, a character was dropped
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting; serves pending clear first, then the held character
// CLEAR_ROW | blanking the cursor row, one cell per cycle
// CLEAR_ALL | blanking the whole screen row-major, then cursor home
module vga_text_cursor
   import vga_text_pkg::*;
#(
   parameter int unsigned COLS       = DEF_COLS,
   parameter int unsigned ROWS       = DEF_ROWS,
   parameter logic [7:0]  BLANK_CHAR = ASCII_BLANK
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       char_ready,
   input  logic [7:0] char_data,
   input  logic       clear_screen,
   output logic       vga_char_wr,
   output logic [7:0] vga_char_in,
   output logic [6:0] vga_char_x,
   output logic [4:0] vga_char_y,
   output logic [6:0] cursor_x,
   output logic [4:0] cursor_y,
   output logic       busy,
   output logic       overflow
);

   localparam logic [6:0] X_LAST = 7'(COLS - 1);
   localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
   localparam logic [7:0] COLS_W = 8'(COLS);

   state_t     state_q, state_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       pend_clr_q, pend_clr_d;
   logic [6:0] sx_q, sx_d;
   logic [4:0] sy_q, sy_d;
   logic [6:0] cx_d;
   logic [4:0] cy_d;
   logic       wr_d;
   logic [7:0] in_d;
   logic [6:0] wx_d;
   logic [4:0] wy_d;
   logic       ovf_d;
   logic       busy_d;
   logic       consume;
   logic [4:0] cy_adv;
   logic [7:0] tab_x;

   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      pend_clr_d  = pend_clr_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      cx_d        = cursor_x;
      cy_d        = cursor_y;
      wr_d        = 1'b0;
      in_d        = vga_char_in;
      wx_d        = vga_char_x;
      wy_d        = vga_char_y;
      ovf_d       = overflow;
      consume     = 1'b0;
      cy_adv      = (cursor_y == Y_LAST) ? 5'd0 : cursor_y + 5'd1;
      // 8-bit so a tab from the last tab stop can reach COLS without wrapping
      tab_x       = {1'b0, cursor_x | 7'd7} + 8'd1;

      if (clear_screen && (state_q != IDLE))
         pend_clr_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (pend_clr_q || clear_screen) begin
               state_d = CLEAR_ALL;
               sx_d    = '0;
               sy_d    = '0;
            end else if (hold_full_q) begin
               consume = 1'b1;
               if (is_printable(hold_data_q)) begin
                  wr_d = 1'b1;
                  in_d = hold_data_q;
                  wx_d = cursor_x;
                  wy_d = cursor_y;
                  if (cursor_x == X_LAST) begin
                     cx_d    = '0;
                     cy_d    = cy_adv;
                     state_d = CLEAR_ROW;
                     sx_d    = '0;
                  end else begin
                     cx_d = cursor_x + 7'd1;
                  end
               end else if ((hold_data_q == ASCII_CR) || (hold_data_q == ASCII_LF)) begin
                  cx_d    = '0;
                  cy_d    = cy_adv;
                  state_d = CLEAR_ROW;
                  sx_d    = '0;
               end else if (hold_data_q == ASCII_BS) begin
                  if (cursor_x != 7'd0) begin
                     cx_d = cursor_x - 7'd1;
                     wr_d = 1'b1;
                     in_d = BLANK_CHAR;
                     wx_d = cursor_x - 7'd1;
                     wy_d = cursor_y;
                  end
               end else if (hold_data_q == ASCII_TAB) begin
                  if (tab_x >= COLS_W) begin
                     cx_d    = '0;
                     cy_d    = cy_adv;
                     state_d = CLEAR_ROW;
                     sx_d    = '0;
                  end else begin
                     cx_d = tab_x[6:0];
                  end
               end
            end
         end
         CLEAR_ROW: begin
            wr_d = 1'b1;
            in_d = BLANK_CHAR;
            wx_d = sx_q;
            wy_d = cursor_y;
            if (sx_q == X_LAST) state_d = IDLE;
            else                sx_d    = sx_q + 7'd1;
         end
         CLEAR_ALL: begin
            wr_d = 1'b1;
            in_d = BLANK_CHAR;
            wx_d = sx_q;
            wy_d = sy_q;
            if (sx_q == X_LAST) begin
               sx_d = '0;
               if (sy_q == Y_LAST) begin
                  state_d    = IDLE;
                  cx_d       = '0;
                  cy_d       = '0;
                  pend_clr_d = 1'b0;
               end else begin
                  sy_d = sy_q + 5'd1;
               end
            end else begin
               sx_d = sx_q + 7'd1;
            end
         end
         default: begin
            state_d = CLEAR_ALL;
            sx_d    = '0;
            sy_d    = '0;
         end
      endcase

      if (consume)
         hold_full_d = 1'b0;

      // The hold register may refill in the same cycle it is consumed
      if (char_ready) begin
         if (!hold_full_q || consume) begin
            hold_full_d = 1'b1;
            hold_data_d = char_data;
         end else begin
            ovf_d = 1'b1;
         end
      end

      busy_d = (state_d != IDLE) || hold_full_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= CLEAR_ALL;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         pend_clr_q  <= 1'b0;
         sx_q        <= '0;
         sy_q        <= '0;
         cursor_x    <= '0;
         cursor_y    <= '0;
         vga_char_wr <= 1'b0;
         vga_char_in <= BLANK_CHAR;
         vga_char_x  <= '0;
         vga_char_y  <= '0;
         overflow    <= 1'b0;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         pend_clr_q  <= pend_clr_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         cursor_x    <= cx_d;
         cursor_y    <= cy_d;
         vga_char_wr <= wr_d;
         vga_char_in <= in_d;
         vga_char_x  <= wx_d;
         vga_char_y  <= wy_d;
         overflow    <= ovf_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_vga_text_cursor.sv
// Self-checking bench for vga_text_cursor. A screen-level model predicts
// the ordered list of character RAM writes and the cursor position for
// each keystroke; the DUT's writes are logged on the falling edge.
module tb_vga_text_cursor;

   localparam int C = 80;
   localparam int R = 30;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       char_ready = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       clear_screen = 1'b0;
   logic       vga_char_wr;
   logic [7:0] vga_char_in;
   logic [6:0] vga_char_x;
   logic [4:0] vga_char_y;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y;
   logic       busy;
   logic       overflow;

   vga_text_cursor dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .char_ready   (char_ready),
      .char_data    (char_data),
      .clear_screen (clear_screen),
      .vga_char_wr  (vga_char_wr),
      .vga_char_in  (vga_char_in),
      .vga_char_x   (vga_char_x),
      .vga_char_y   (vga_char_y),
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] c;
      int         x;
      int         y;
   } wr_t;

   wr_t got[$];
   wr_t exp_q[$];
   wr_t mon_w;
   int  checks = 0;
   int  errors = 0;
   int  mx = 0;
   int  my = 0;

   always @(negedge clk) begin
      if (vga_char_wr === 1'b1) begin
         mon_w.c = vga_char_in;
         mon_w.x = int'(vga_char_x);
         mon_w.y = int'(vga_char_y);
         got.push_back(mon_w);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic exp_push(input logic [7:0] c, input int x, input int y);
      wr_t w;
      w.c = c; w.x = x; w.y = y;
      exp_q.push_back(w);
   endtask

   task automatic m_newline();
      mx = 0;
      my = (my + 1) % R;
      for (int i = 0; i < C; i++) exp_push(8'h20, i, my);
   endtask

   task automatic m_full_clear();
      for (int y = 0; y < R; y++)
         for (int x = 0; x < C; x++) exp_push(8'h20, x, y);
      mx = 0;
      my = 0;
   endtask

   task automatic m_char(input logic [7:0] c);
      int t;
      if (c >= 8'h20 && c <= 8'h7E) begin
         exp_push(c, mx, my);
         if (mx == C - 1) m_newline();
         else             mx++;
      end else if (c == 8'h0D || c == 8'h0A) begin
         m_newline();
      end else if (c == 8'h08) begin
         if (mx > 0) begin
            mx--;
            exp_push(8'h20, mx, my);
         end
      end else if (c == 8'h09) begin
         t = (mx / 8 + 1) * 8;
         if (t >= C) m_newline();
         else        mx = t;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // All helpers start and end at posedge+1.
   task automatic send(input logic [7:0] c);
      char_data  = c;
      char_ready = 1'b1;
      @(posedge clk); #1;
      char_ready = 1'b0;
      m_char(c);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n = 0;
      while (busy !== 1'b0 && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_idle"}, int'(busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic cmp_log(input string tag);
      int bad = 0;
      chk({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i].c !== exp_q[i].c || got[i].x != exp_q[i].x || got[i].y != exp_q[i].y)
            bad++;
      chk({tag, "_content"}, bad, 0);
      chk({tag, "_cx"}, int'(cursor_x), mx);
      chk({tag, "_cy"}, int'(cursor_y), my);
      got.delete();
      exp_q.delete();
   endtask

   task automatic key(input string tag, input logic [7:0] c);
      send(c);
      wait_idle(tag, 300);
      cmp_log(tag);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr"},   int'(vga_char_wr), 0);
      chk({tag, "_in"},   int'(vga_char_in), 32);
      chk({tag, "_x"},    int'(vga_char_x), 0);
      chk({tag, "_y"},    int'(vga_char_y), 0);
      chk({tag, "_cx"},   int'(cursor_x), 0);
      chk({tag, "_cy"},   int'(cursor_y), 0);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_ovf"},  int'(overflow), 0);
   endtask

   initial begin
      int low;
      int n;
      int r;
      logic [7:0] c;

      // reset and power-up clear
      #2 reset_n = 1'b0;
      #2 chk_reset("rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      got.delete();
      reset_n = 1'b1;
      @(posedge clk); #1;
      m_full_clear();
      wait_idle("init", 3000);
      cmp_log("init");

      // move to (5,3), then check write latency of 'A'
      for (int i = 0; i < 3; i++) key("nl", 8'h0A);
      for (int i = 0; i < 5; i++) key("pre", 8'h30 + 8'(i));
      send(8'h41);
      @(posedge clk); #1;
      chk("lat_wr", int'(vga_char_wr), 1);
      chk("lat_in", int'(vga_char_in), 8'h41);
      chk("lat_x",  int'(vga_char_x), 5);
      chk("lat_y",  int'(vga_char_y), 3);
      chk("lat_cx", int'(cursor_x), 6);
      chk("lat_cy", int'(cursor_y), 3);
      wait_idle("A", 300);
      cmp_log("A");

      // randomized keystrokes
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            6:       c = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            7:       c = 8'h08;
            8:       c = 8'h09;
            9:       c = 8'($urandom_range(127, 255));
            default: c = 8'($urandom_range(32, 126));
         endcase
         key("rnd", c);
      end

      // go to (79,29) and wrap the screen
      while (my != R - 1) key("nav_y", 8'h0A);
      while (mx != C - 1) key("nav_x", 8'h61);
      send(8'h5A);
      low = 0;
      n = 0;
      while (got.size() < 80 && n < 300) begin
         if (busy !== 1'b1) low++;
         @(posedge clk); #1;
         n++;
      end
      chk("wrap_busy_low", low, 0);
      wait_idle("wrap", 300);
      cmp_log("wrap");

      // tab near end of line, backspace cases, ignored code
      while (mx != 77) key("to77", 8'h62);
      key("tab77", 8'h09);
      key("bs_x0", 8'h08);
      key("nl2", 8'h0A);
      for (int i = 0; i < 10; i++) key("to10", 8'h63);
      key("bs10", 8'h08);
      key("bel", 8'h07);
      chk("ovf_clean", int'(overflow), 0);

      // overflow: three strobes during a row clear
      send(8'h0A);
      @(posedge clk); #1;
      char_data = 8'h78; char_ready = 1'b1;
      @(posedge clk); #1;
      char_ready = 1'b0;
      m_char(8'h78);
      @(posedge clk); #1;
      char_data = 8'h79; char_ready = 1'b1;
      @(posedge clk); #1;
      char_ready = 1'b0;
      @(posedge clk); #1;
      char_data = 8'h7A; char_ready = 1'b1;
      @(posedge clk); #1;
      char_ready = 1'b0;
      chk("ovf_set", int'(overflow), 1);
      wait_idle("ovf", 300);
      cmp_log("ovf");
      key("after_ovf", 8'h71);
      chk("ovf_sticky", int'(overflow), 1);

      // clear_screen during row clear, then reset in the middle of the full clear
      send(8'h0A);
      repeat (5) @(posedge clk);
      #1 clear_screen = 1'b1;
      @(posedge clk); #1;
      clear_screen = 1'b0;
      n = 0;
      while (got.size() < 580 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pend_reached", int'(got.size() >= 580), 1);
      if (got.size() >= 580) begin
         chk("pend_first_x", got[80].x, 0);
         chk("pend_first_y", got[80].y, 0);
         chk("pend_last_x", got[579].x, 499 % C);
         chk("pend_last_y", got[579].y, 499 / C);
      end
      reset_n = 1'b0;
      #1 chk_reset("midrst");
      got.delete();
      exp_q.delete();
      @(negedge clk);
      got.delete();
      reset_n = 1'b1;
      @(posedge clk); #1;
      m_full_clear();
      wait_idle("reclear", 3000);
      cmp_log("reclear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
